// File: rtl/ebr_port_scheduler.sv
// ============================================================================
// Module      : ebr_port_scheduler
// Description : Round-robin time-sharing of EBR page buffer port A between the
//               host and NAND burst engines, with burst address sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ebr_port_scheduler #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    // host requester
    input  logic              i_h_req,
    input  logic              i_h_wr,
    input  logic [ADDR_W-1:0] i_h_addr,
    input  logic [LEN_W-1:0]  i_h_len,
    input  logic [DATA_W-1:0] i_h_wdata,
    input  logic              i_h_wvalid,
    output logic              o_h_ack,
    output logic              o_h_wready,
    output logic [DATA_W-1:0] o_h_rdata,
    output logic              o_h_rvalid,
    output logic              o_h_done,
    // NAND requester
    input  logic              i_n_req,
    input  logic              i_n_wr,
    input  logic [ADDR_W-1:0] i_n_addr,
    input  logic [LEN_W-1:0]  i_n_len,
    input  logic [DATA_W-1:0] i_n_wdata,
    input  logic              i_n_wvalid,
    output logic              o_n_ack,
    output logic              o_n_wready,
    output logic [DATA_W-1:0] o_n_rdata,
    output logic              o_n_rvalid,
    output logic              o_n_done,
    // buffer port A
    output logic [ADDR_W-1:0] o_buf_addr,
    output logic [DATA_W-1:0] o_buf_data_in,
    output logic              o_buf_wr,
    output logic              o_buf_clock_en,
    input  logic [DATA_W-1:0] i_buf_q,
    // status
    output logic              o_busy,
    output logic              o_owner
);

    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(1 << ADDR_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_owner;
    logic                r_rr_last;     // 1 = NAND was granted last
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [LEN_W-1:0]    r_remain;
    logic                r_h_rvalid;
    logic                r_n_rvalid;
    logic [DATA_W-1:0]   r_h_rdata;
    logic [DATA_W-1:0]   r_n_rdata;

    logic                w_grant_any;
    logic                w_grant_sel;
    logic [LEN_W-1:0]    w_sel_len;
    logic [LEN_W-1:0]    w_len_clamped;
    logic                w_own_wvalid;
    logic [DATA_W-1:0]   w_own_wdata;
    logic                w_xfer;
    logic                w_beat;
    logic                w_last_beat;

    // Arbitration is only open in IDLE; a grant during reset would be lost.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_sel = 1'b0;
        if ((r_state == S_IDLE) && !rst) begin
            if (i_h_req && i_n_req) begin
                w_grant_any = 1'b1;
                w_grant_sel = ~r_rr_last;
            end else if (i_h_req) begin
                w_grant_any = 1'b1;
                w_grant_sel = 1'b0;
            end else if (i_n_req) begin
                w_grant_any = 1'b1;
                w_grant_sel = 1'b1;
            end
        end
    end

    assign w_sel_len     = w_grant_sel ? i_n_len : i_h_len;
    assign w_len_clamped = (w_sel_len > C_MAX_LEN) ? C_MAX_LEN : w_sel_len;
    assign w_own_wvalid  = r_owner ? i_n_wvalid : i_h_wvalid;
    assign w_own_wdata   = r_owner ? i_n_wdata  : i_h_wdata;
    assign w_xfer        = (r_state == S_XFER);
    assign w_beat        = w_xfer && (!r_wr || w_own_wvalid);
    assign w_last_beat   = w_beat && (r_remain == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_any) begin
                    w_next_state = (w_len_clamped == '0) ? S_DRAIN : S_XFER;
                end
            end
            S_XFER: begin
                if (w_last_beat) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= 1'b0;
            r_rr_last   <= 1'b1;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_last_addr <= '0;
            r_remain    <= '0;
            r_h_rvalid  <= 1'b0;
            r_n_rvalid  <= 1'b0;
            r_h_rdata   <= '0;
            r_n_rdata   <= '0;
        end else begin
            // QA is registered inside the EBR, so data returns one cycle after the strobe.
            r_h_rvalid <= w_xfer && !r_wr && !r_owner;
            r_n_rvalid <= w_xfer && !r_wr &&  r_owner;
            if (r_h_rvalid) begin
                r_h_rdata <= i_buf_q;
            end
            if (r_n_rvalid) begin
                r_n_rdata <= i_buf_q;
            end
            if (w_grant_any) begin
                r_owner   <= w_grant_sel;
                r_rr_last <= w_grant_sel;
                r_wr      <= w_grant_sel ? i_n_wr   : i_h_wr;
                r_addr    <= w_grant_sel ? i_n_addr : i_h_addr;
                r_remain  <= w_len_clamped;
            end else if (w_beat) begin
                r_addr      <= r_addr + 1'b1;
                r_remain    <= r_remain - 1'b1;
                r_last_addr <= r_addr;
            end
        end
    end

    always_comb begin
        o_buf_clock_en = w_xfer && (r_wr ? w_own_wvalid : 1'b1);
        o_buf_wr       = w_xfer && r_wr;
        o_buf_addr     = w_xfer ? r_addr : r_last_addr;
        o_buf_data_in  = (w_xfer && r_wr) ? w_own_wdata : '0;

        o_h_ack    = w_grant_any && !w_grant_sel;
        o_n_ack    = w_grant_any &&  w_grant_sel;
        o_h_wready = w_xfer && r_wr && !r_owner && i_h_wvalid;
        o_n_wready = w_xfer && r_wr &&  r_owner && i_n_wvalid;
        o_h_done   = (r_state == S_DRAIN) && !r_owner;
        o_n_done   = (r_state == S_DRAIN) &&  r_owner;
        o_h_rvalid = r_h_rvalid;
        o_n_rvalid = r_n_rvalid;
        o_h_rdata  = r_h_rvalid ? i_buf_q : r_h_rdata;
        o_n_rdata  = r_n_rvalid ? i_buf_q : r_n_rdata;

        o_busy  = (r_state != S_IDLE);
        o_owner = r_owner;
    end

endmodule

`default_nettype wire

// File: tb/tb_ebr_port_scheduler.sv
// ============================================================================
// Module      : tb_ebr_port_scheduler
// Description : Self-checking bench for ebr_port_scheduler with an EBR model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ebr_port_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_h_req = 0, i_h_wr = 0, i_h_wvalid = 0;
    logic [10:0] i_h_addr = 0;
    logic [11:0] i_h_len = 0;
    logic [7:0]  i_h_wdata = 0;
    logic        i_n_req = 0, i_n_wr = 0, i_n_wvalid = 0;
    logic [10:0] i_n_addr = 0;
    logic [11:0] i_n_len = 0;
    logic [7:0]  i_n_wdata = 0;
    logic        o_h_ack, o_h_wready, o_h_rvalid, o_h_done;
    logic        o_n_ack, o_n_wready, o_n_rvalid, o_n_done;
    logic [7:0]  o_h_rdata, o_n_rdata, o_buf_data_in;
    logic [10:0] o_buf_addr;
    logic        o_buf_wr, o_buf_clock_en, o_busy, o_owner;
    logic [7:0]  bq;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0]  ref_mem [2048];
    logic [7:0]  exp_rdata [2];
    logic [10:0] exp_last_addr;
    bit          rr_last;          // side granted last (1 = NAND)

    // EBR port A model
    logic [7:0]  bmem [2048];
    bit          seed_buf = 1'b1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (seed_buf) begin
            for (int i = 0; i < 2048; i++) bmem[i] <= ref_mem[i];
        end else if (o_buf_clock_en) begin
            if (o_buf_wr) bmem[o_buf_addr] <= o_buf_data_in;
            else          bq <= bmem[o_buf_addr];
        end
    end

    ebr_port_scheduler dut (
        .clk(clk), .rst(rst),
        .i_h_req(i_h_req), .i_h_wr(i_h_wr), .i_h_addr(i_h_addr), .i_h_len(i_h_len),
        .i_h_wdata(i_h_wdata), .i_h_wvalid(i_h_wvalid),
        .o_h_ack(o_h_ack), .o_h_wready(o_h_wready), .o_h_rdata(o_h_rdata),
        .o_h_rvalid(o_h_rvalid), .o_h_done(o_h_done),
        .i_n_req(i_n_req), .i_n_wr(i_n_wr), .i_n_addr(i_n_addr), .i_n_len(i_n_len),
        .i_n_wdata(i_n_wdata), .i_n_wvalid(i_n_wvalid),
        .o_n_ack(o_n_ack), .o_n_wready(o_n_wready), .o_n_rdata(o_n_rdata),
        .o_n_rvalid(o_n_rvalid), .o_n_done(o_n_done),
        .o_buf_addr(o_buf_addr), .o_buf_data_in(o_buf_data_in), .o_buf_wr(o_buf_wr),
        .o_buf_clock_en(o_buf_clock_en), .i_buf_q(bq),
        .o_busy(o_busy), .o_owner(o_owner)
    );

    // One complete burst by one requester; wv_mode 0 = WValid always, 1 = random, 2 = 1,0,0,1,1
    task automatic run_burst(input bit side, input bit wr, input int addr, input int len,
                             input int wv_mode, input bit drand, input logic [7:0] dbase);
        int          eff, k, cyc, strobes;
        bit          prev_rd, done_seen, is_xfer, wv;
        logic [10:0] prev_addr, a;
        logic [7:0]  wd, e_own_rd, o_own_rd, o_oth_rd;
        logic [21:0] e_vec, o_vec;
        logic [4:0]  pat;
        pat = 5'b11001;
        eff = (len > 2048) ? 2048 : len;
        @(negedge clk);
        if (side) begin i_n_req = 1; i_n_wr = wr; i_n_addr = 11'(addr); i_n_len = 12'(len); end
        else      begin i_h_req = 1; i_h_wr = wr; i_h_addr = 11'(addr); i_h_len = 12'(len); end
        #1;
        n_checks++;
        if ({o_h_ack, o_n_ack} !== (side ? 2'b01 : 2'b10)) begin
            n_fail++;
            $display("FAIL grant_ack side=%0d got h/n=%b%b", side, o_h_ack, o_n_ack);
        end
        rr_last = side;
        k = 0; cyc = 0; strobes = 0; prev_rd = 0; done_seen = 0; prev_addr = 0;
        while (!done_seen && cyc < 5000) begin
            @(negedge clk);
            i_h_req = 0; i_n_req = 0;
            i_h_wr = 1'($urandom); i_n_wr = 1'($urandom);
            i_h_addr = 11'($urandom); i_n_addr = 11'($urandom);
            case (wv_mode)
                0:       wv = 1;
                1:       wv = (cyc > 200) ? 1'b1 : 1'($urandom);
                default: wv = (cyc < 5) ? pat[cyc] : 1'b1;
            endcase
            wd = drand ? 8'($urandom) : 8'(dbase + 8'(k));
            if (side) begin
                i_n_wvalid = wv; i_n_wdata = wd;
                i_h_wvalid = 1'($urandom); i_h_wdata = 8'($urandom);
            end else begin
                i_h_wvalid = wv; i_h_wdata = wd;
                i_n_wvalid = 1'($urandom); i_n_wdata = 8'($urandom);
            end
            #1;
            is_xfer = (k < eff);
            a = 11'((addr + k) % 2048);
            e_own_rd = prev_rd ? ref_mem[prev_addr] : exp_rdata[side];
            e_vec = {1'b1, side,
                     is_xfer && (wr ? wv : 1'b1), is_xfer && wr,
                     is_xfer ? a : exp_last_addr,
                     2'b00,
                     !side && is_xfer && wr && wv, side && is_xfer && wr && wv,
                     !side && prev_rd, side && prev_rd,
                     !side && !is_xfer, side && !is_xfer};
            o_vec = {o_busy, o_owner, o_buf_clock_en, o_buf_wr, o_buf_addr,
                     o_h_ack, o_n_ack, o_h_wready, o_n_wready,
                     o_h_rvalid, o_n_rvalid, o_h_done, o_n_done};
            n_checks++;
            if (o_vec !== e_vec) begin
                n_fail++;
                $display("FAIL burst_ctrl cyc=%0d beat=%0d got %b want %b", cyc, k, o_vec, e_vec);
            end
            o_own_rd = side ? o_n_rdata : o_h_rdata;
            o_oth_rd = side ? o_h_rdata : o_n_rdata;
            n_checks++;
            if ({o_own_rd, o_oth_rd} !== {e_own_rd, exp_rdata[!side]}) begin
                n_fail++;
                $display("FAIL rdata cyc=%0d got own=%h other=%h want own=%h other=%h",
                         cyc, o_own_rd, o_oth_rd, e_own_rd, exp_rdata[!side]);
            end
            if (is_xfer && wr) begin
                n_checks++;
                if (o_buf_data_in !== wd) begin
                    n_fail++;
                    $display("FAIL buf_data_in cyc=%0d got %h want %h", cyc, o_buf_data_in, wd);
                end
            end
            if (o_buf_clock_en === 1'b1) strobes++;
            if (prev_rd) exp_rdata[side] = ref_mem[prev_addr];
            prev_rd = 0;
            if (is_xfer) begin
                if (!wr || wv) begin
                    if (wr) ref_mem[a] = wd;
                    exp_last_addr = a;
                    prev_rd = !wr;
                    prev_addr = a;
                    k++;
                end
            end else begin
                done_seen = 1;
            end
            cyc++;
        end
        n_checks++;
        if (!done_seen || strobes != eff) begin
            n_fail++;
            $display("FAIL burst_strobes got %0d want %0d (done_seen=%0d)", strobes, eff, done_seen);
        end
        @(negedge clk);
        i_h_wvalid = 0; i_n_wvalid = 0;
        #1;
        n_checks++;
        if ({o_busy, o_buf_clock_en, o_buf_wr, o_buf_addr, o_h_ack, o_n_ack, o_h_done, o_n_done,
             o_h_rvalid, o_n_rvalid, o_h_rdata, o_n_rdata} !==
            {3'b000, exp_last_addr, 6'b0, exp_rdata[0], exp_rdata[1]}) begin
            n_fail++;
            $display("FAIL idle_after_burst got busy=%b ce=%b addr=%h rd=%h/%h want addr=%h rd=%h/%h",
                     o_busy, o_buf_clock_en, o_buf_addr, o_h_rdata, o_n_rdata,
                     exp_last_addr, exp_rdata[0], exp_rdata[1]);
        end
    endtask

    task automatic test_reset();
        rst = 1; seed_buf = 1;
        repeat (3) @(negedge clk);
        rst = 0; seed_buf = 0;
        #1;
        rr_last = 1; exp_last_addr = 0; exp_rdata[0] = 0; exp_rdata[1] = 0;
        n_checks++;
        if ({o_h_ack, o_h_wready, o_h_rdata, o_h_rvalid, o_h_done,
             o_n_ack, o_n_wready, o_n_rdata, o_n_rvalid, o_n_done,
             o_buf_addr, o_buf_data_in, o_buf_wr, o_buf_clock_en, o_busy, o_owner} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_outputs not all zero: busy=%b addr=%h rd=%h/%h",
                     o_busy, o_buf_addr, o_h_rdata, o_n_rdata);
        end
    endtask

    task automatic test_basic();
        run_burst(0, 1, 16, 4, 0, 0, 8'hA0);
        run_burst(0, 0, 16, 4, 0, 0, 8'h00);
    endtask

    task automatic test_stall();
        int a;
        a = int'($urandom_range(0, 2000));
        run_burst(1, 1, a, 3, 2, 1, 8'h00);
        run_burst(1, 0, a, 3, 0, 0, 8'h00);
        run_burst(0, 1, a + 5, 12, 1, 1, 8'h00);
        run_burst(1, 0, a + 5, 12, 0, 0, 8'h00);
    endtask

    task automatic test_wrap();
        run_burst(0, 1, 2046, 4, 0, 0, 8'h5C);
        run_burst(1, 0, 2046, 4, 0, 0, 8'h00);
    endtask

    task automatic test_len_edges();
        run_burst(0, 0, 100, 0, 0, 0, 8'h00);
        run_burst(1, 1, 200, 0, 0, 0, 8'h00);
        run_burst(0, 0, int'($urandom_range(0, 2047)), 12'hFFF, 0, 0, 8'h00);
    endtask

    task automatic test_reset_abort();
        logic [10:0] a, idx;
        logic [7:0]  d;
        a = 11'($urandom_range(0, 2047));
        @(negedge clk);
        i_h_req = 1; i_h_wr = 1; i_h_addr = a; i_h_len = 10;
        #1;
        n_checks++;
        if (o_h_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ack got %b want 1", o_h_ack);
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            i_h_req = 0; d = 8'($urandom); i_h_wvalid = 1; i_h_wdata = d;
            if (b == 2) rst = 1;
            #1;
            idx = 11'(a + 11'(b));
            n_checks++;
            if ({o_buf_clock_en, o_buf_wr, o_buf_addr} !== {2'b11, idx}) begin
                n_fail++;
                $display("FAIL abort_beat b=%0d got ce=%b wr=%b addr=%h want addr=%h",
                         b, o_buf_clock_en, o_buf_wr, o_buf_addr, idx);
            end
            ref_mem[idx] = d;
        end
        @(negedge clk);
        rst = 0; i_h_wvalid = 0;
        #1;
        rr_last = 1; exp_last_addr = 0; exp_rdata[0] = 0; exp_rdata[1] = 0;
        n_checks++;
        if ({o_h_ack, o_h_wready, o_h_rdata, o_h_rvalid, o_h_done,
             o_n_ack, o_n_wready, o_n_rdata, o_n_rvalid, o_n_done,
             o_buf_addr, o_buf_data_in, o_buf_wr, o_buf_clock_en, o_busy, o_owner} !== 48'd0) begin
            n_fail++;
            $display("FAIL abort_outputs not zero: busy=%b done=%b%b ce=%b addr=%h",
                     o_busy, o_h_done, o_n_done, o_buf_clock_en, o_buf_addr);
        end
        run_burst(1, 0, int'(a), 10, 0, 0, 8'h00);
    endtask

    task automatic test_arbitration();
        logic [1:0] e, o;
        bit g;
        g = 0;
        @(negedge clk);
        i_h_req = 1; i_n_req = 1; i_h_len = 0; i_n_len = 0;
        i_h_wr = 1'($urandom); i_n_wr = 1'($urandom);
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (c % 2 == 0) begin
                g = !rr_last; rr_last = g;
                o = {o_h_ack, o_n_ack};
            end else begin
                o = {o_h_done, o_n_done};
            end
            e = g ? 2'b01 : 2'b10;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL arb_both c=%0d got %b want %b", c, o, e);
            end
        end
        @(negedge clk);
        i_h_req = 0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            o = (c % 2 == 0) ? {o_h_ack, o_n_ack} : {o_h_done, o_n_done};
            n_checks++;
            if (o !== 2'b01) begin
                n_fail++;
                $display("FAIL arb_n_only c=%0d got %b want 01", c, o);
            end
        end
        rr_last = 1;
        @(negedge clk);
        i_n_req = 0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 20; t++) begin
            run_burst(1'($urandom), 1'($urandom), int'($urandom_range(0, 2047)),
                      int'($urandom_range(0, 24)), 1, 1, 8'h00);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'($urandom);
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_len_edges();
        test_reset_abort();
        test_arbitration();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
